instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 53 +++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one instruction word at a time into ir, with stall, redirect and halt control.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic        ir_valid,
    input  logic        ir_ready
);
    typedef enum logic [1:0] {REQ, HOLD, HALTED} state_t;
    state_t state;
    logic [31:0] pc;
    // Gating with rst/halt keeps the request low in the reset cycle and the halt cycle.
    assign imem_req = state == REQ && !stall && !halt && !rst;
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            ir <= '0;
            pc_out <= '0;
            ir_valid <= 1'b0;
        end else if (state != HALTED) begin
            if (halt) begin
                state <= HALTED;
                ir_valid <= 1'b0;
            end else if (redirect_valid) begin
                state <= REQ;
                pc <= redirect_pc;
                ir_valid <= 1'b0;
            end else if (imem_req && imem_ack) begin
                state <= HOLD;
                ir <= imem_rdata;
                pc_out <= pc;
                pc <= pc + 32'd1;
                ir_valid <= 1'b1;
            end else if (state == HOLD && ir_ready) begin
                state <= REQ;
                ir_valid <= 1'b0;
            end
        end
    end
endmodule
